mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory-controller and status signals of the shared RAM port arbiter.
// The slave view belongs to the arbiter; the master view belongs to its surroundings.
interface mem_port_arbiter_if #(
   parameter int unsigned XLEN = 32
);
   localparam int unsigned SIZE_W = 2;

   logic [XLEN-1:0]   i_addr;
   logic              i_read;
   logic [XLEN-1:0]   i_rdata;
   logic              i_ready;

   logic [XLEN-1:0]   d_addr;
   logic              d_read;
   logic              d_write;
   logic [XLEN-1:0]   d_wdata;
   logic [SIZE_W-1:0] d_byte_size;
   logic [XLEN-1:0]   d_rdata;
   logic              d_ready;

   logic [XLEN-1:0]   mem_io_addr;
   logic [XLEN-1:0]   mem_io_wdata;
   logic              mem_io_read;
   logic              mem_io_write;
   logic [SIZE_W-1:0] io_byte_size;
   logic [XLEN-1:0]   mem_io_rdata;
   logic              mem_io_ready;

   logic              busy;
   logic              timeout_err;

   modport slave (
      input  i_addr, i_read, d_addr, d_read, d_write, d_wdata, d_byte_size,
      input  mem_io_rdata, mem_io_ready,
      output i_rdata, i_ready, d_rdata, d_ready,
      output mem_io_addr, mem_io_wdata, mem_io_read, mem_io_write, io_byte_size,
      output busy, timeout_err
   );

   modport master (
      output i_addr, i_read, d_addr, d_read, d_write, d_wdata, d_byte_size,
      output mem_io_rdata, mem_io_ready,
      input  i_rdata, i_ready, d_rdata, d_ready,
      input  mem_io_addr, mem_io_wdata, mem_io_read, mem_io_write, io_byte_size,
      input  busy, timeout_err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one RAM controller port between instruction fetch
// and load/store, with registered memory-side signals and a BUSY watchdog.
module mem_port_arbiter #(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic               ramclk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);

   localparam int unsigned WDT_W  = 8;
   localparam int unsigned SIZE_W = 2;
   localparam bit          WDT_EN = (TIMEOUT_CYCLES != 0);
   // Count of already completed BUSY cycles at which the current one is the last allowed.
   localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} owner_t;
   typedef enum logic {GR_FETCH, GR_DATA} grant_t;

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   grant_t            last_q, last_d;
   logic [WDT_W-1:0]  wdt_q, wdt_d;
   logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
   logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [SIZE_W-1:0] size_q, size_d;
   logic [XLEN-1:0]   i_rdata_q, i_rdata_d;
   logic              i_ready_q, i_ready_d;
   logic [XLEN-1:0]   d_rdata_q, d_rdata_d;
   logic              d_ready_q, d_ready_d;
   logic              busy_q, busy_d;
   logic              terr_q, terr_d;

   logic req_fetch_c, req_data_c, grant_c, pick_data_c, wdt_expire_c;

   assign req_fetch_c  = bus.i_read;
   assign req_data_c   = bus.d_read | bus.d_write;
   // A ready still high from the previous transaction blocks arbitration.
   assign grant_c      = (state_q == ST_IDLE) && !bus.mem_io_ready && (req_fetch_c || req_data_c);
   assign pick_data_c  = req_data_c && (!req_fetch_c || (last_q == GR_FETCH));
   assign wdt_expire_c = WDT_EN && (wdt_q == WDT_LAST);

   // State and output registers
   always_ff @(posedge ramclk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWN_NONE;
         last_q      <= GR_FETCH;
         wdt_q       <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         size_q      <= '0;
         i_rdata_q   <= '0;
         i_ready_q   <= 1'b0;
         d_rdata_q   <= '0;
         d_ready_q   <= 1'b0;
         busy_q      <= 1'b0;
         terr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         wdt_q       <= wdt_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         size_q      <= size_d;
         i_rdata_q   <= i_rdata_d;
         i_ready_q   <= i_ready_d;
         d_rdata_q   <= d_rdata_d;
         d_ready_q   <= d_ready_d;
         busy_q      <= busy_d;
         terr_q      <= terr_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (grant_c) state_d = ST_BUSY;
         ST_BUSY: if (bus.mem_io_ready || wdt_expire_c) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs and bookkeeping
   always_comb begin
      owner_d     = owner_q;
      last_d      = last_q;
      wdt_d       = wdt_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      size_d      = size_q;
      i_rdata_d   = i_rdata_q;
      i_ready_d   = i_ready_q;
      d_rdata_d   = d_rdata_q;
      d_ready_d   = d_ready_q;
      terr_d      = terr_q;
      busy_d      = (state_d != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (grant_c) begin
               wdt_d = '0;
               if (pick_data_c) begin
                  owner_d     = OWN_DATA;
                  last_d      = GR_DATA;
                  mem_addr_d  = bus.d_addr;
                  mem_wdata_d = bus.d_wdata;
                  size_d      = bus.d_byte_size;
                  mem_write_d = bus.d_write;
                  mem_read_d  = bus.d_read && !bus.d_write;
               end else begin
                  owner_d     = OWN_FETCH;
                  last_d      = GR_FETCH;
                  mem_addr_d  = bus.i_addr;
                  size_d      = '0;
                  mem_write_d = 1'b0;
                  mem_read_d  = 1'b1;
               end
            end
         end
         ST_BUSY: begin
            if (bus.mem_io_ready || wdt_expire_c) begin
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               terr_d      = !bus.mem_io_ready;
               if (owner_q == OWN_DATA) begin
                  d_ready_d = 1'b1;
                  d_rdata_d = bus.mem_io_ready ? bus.mem_io_rdata : '0;
               end else begin
                  i_ready_d = 1'b1;
                  i_rdata_d = bus.mem_io_ready ? bus.mem_io_rdata : '0;
               end
            end else begin
               wdt_d = wdt_q + WDT_W'(1);
            end
         end
         ST_DONE: begin
            i_ready_d = 1'b0;
            d_ready_d = 1'b0;
            terr_d    = 1'b0;
            owner_d   = OWN_NONE;
         end
         default: ;
      endcase
   end

   assign bus.mem_io_addr  = mem_addr_q;
   assign bus.mem_io_wdata = mem_wdata_q;
   assign bus.mem_io_read  = mem_read_q;
   assign bus.mem_io_write = mem_write_q;
   assign bus.io_byte_size = size_q;
   assign bus.i_rdata      = i_rdata_q;
   assign bus.i_ready      = i_ready_q;
   assign bus.d_rdata      = d_rdata_q;
   assign bus.d_ready      = d_ready_q;
   assign bus.busy         = busy_q;
   assign bus.timeout_err  = terr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level
// reference model, with a behavioural RAM controller and two requesters.
module tb_mem_port_arbiter;

   localparam int unsigned XLEN = 32;
   localparam int unsigned TO   = 8;

   logic ramclk;
   logic rst;

   initial ramclk = 1'b0;
   always #5 ramclk = ~ramclk;

   mem_port_arbiter_if #(.XLEN(XLEN)) bus ();

   mem_port_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
      .ramclk(ramclk),
      .rst   (rst),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: expected outputs plus the outstanding transaction
   logic [31:0] e_addr, e_wdata, e_i_rdata, e_d_rdata;
   logic [1:0]  e_size;
   logic        e_rd, e_wr, e_i_rdy, e_d_rdy, e_busy, e_terr;
   bit          m_active, m_retire, m_owner_data, m_last_data;
   int          m_cycles;

   task automatic model_step();
      logic [31:0] v;
      bit want_i, want_d;
      if (rst) begin
         {e_addr, e_wdata, e_i_rdata, e_d_rdata} = '0;
         e_size = '0;
         {e_rd, e_wr, e_i_rdy, e_d_rdy, e_busy, e_terr} = '0;
         m_active = 0; m_retire = 0; m_last_data = 0; m_cycles = 0;
      end else if (m_retire) begin
         e_i_rdy = 0; e_d_rdy = 0; e_terr = 0; e_busy = 0;
         m_retire = 0;
      end else if (m_active) begin
         m_cycles++;
         if (bus.mem_io_ready || m_cycles == TO) begin
            v = bus.mem_io_ready ? bus.mem_io_rdata : 32'h0;
            if (m_owner_data) begin e_d_rdata = v; e_d_rdy = 1; end
            else              begin e_i_rdata = v; e_i_rdy = 1; end
            e_terr = !bus.mem_io_ready;
            e_rd = 0; e_wr = 0;
            m_active = 0; m_retire = 1;
         end
      end else if (!bus.mem_io_ready && (bus.i_read || bus.d_read || bus.d_write)) begin
         want_i = bus.i_read;
         want_d = bus.d_read || bus.d_write;
         // The loser of the previous grant wins a tie.
         m_owner_data = want_d && (!want_i || !m_last_data);
         m_last_data  = m_owner_data;
         if (m_owner_data) begin
            e_addr = bus.d_addr; e_wdata = bus.d_wdata; e_size = bus.d_byte_size;
            e_wr = bus.d_write; e_rd = !bus.d_write;
         end else begin
            e_addr = bus.i_addr; e_size = 2'd0; e_wr = 0; e_rd = 1;
         end
         m_active = 1; e_busy = 1; m_cycles = 0;
      end
   endtask

   task automatic compare_all();
      check_eq("mem_io_read",  32'(bus.mem_io_read),  32'(e_rd));
      check_eq("mem_io_write", 32'(bus.mem_io_write), 32'(e_wr));
      check_eq("busy",         32'(bus.busy),         32'(e_busy));
      check_eq("i_ready",      32'(bus.i_ready),      32'(e_i_rdy));
      check_eq("d_ready",      32'(bus.d_ready),      32'(e_d_rdy));
      check_eq("timeout_err",  32'(bus.timeout_err),  32'(e_terr));
      check_eq("i_rdata",      bus.i_rdata,           e_i_rdata);
      check_eq("d_rdata",      bus.d_rdata,           e_d_rdata);
      if (e_rd || e_wr) begin
         check_eq("mem_io_addr",  bus.mem_io_addr,       e_addr);
         check_eq("io_byte_size", 32'(bus.io_byte_size), 32'(e_size));
      end
      if (e_wr) check_eq("mem_io_wdata", bus.mem_io_wdata, e_wdata);
   endtask

   // Behavioural RAM controller
   bit          c_seen, c_use_fixed;
   int          c_wait, c_hold, c_drop, c_lat_fixed, c_lat_max, c_hold_lo, c_hold_hi;
   logic [31:0] c_fixed;

   task automatic ctrl_reset();
      c_seen = 0; c_wait = -1; c_hold = 0; c_drop = 0; c_lat_fixed = -1;
      c_lat_max = 5; c_hold_lo = 1; c_hold_hi = 1; c_use_fixed = 0; c_fixed = '0;
      bus.mem_io_ready = 1'b0;
      bus.mem_io_rdata = '0;
   endtask

   task automatic controller_step();
      bit strobe;
      strobe = bus.mem_io_read || bus.mem_io_write;
      if (c_hold > 0) begin
         c_hold--;
         if (c_hold == 0) bus.mem_io_ready = 1'b0;
      end else begin
         if (c_wait < 0 && strobe && !c_seen) begin
            c_seen = 1;
            if (c_drop > 0) c_drop--;
            else c_wait = (c_lat_fixed >= 0) ? c_lat_fixed : int'($urandom_range(c_lat_max, 0));
         end
         if (c_wait == 0) begin
            bus.mem_io_ready = 1'b1;
            bus.mem_io_rdata = c_use_fixed ? c_fixed : $urandom;
            c_hold = int'($urandom_range(c_hold_hi, c_hold_lo));
            c_wait = -1;
         end else if (c_wait > 0) begin
            c_wait--;
         end
      end
      if (!strobe) c_seen = 0;
   endtask

   // Random requesters: hold a level request until its ready is seen
   bit rand_mode, i_pend, d_pend;

   task automatic requester_step();
      int op;
      if (i_pend && bus.i_ready) i_pend = 0;
      if (d_pend && bus.d_ready) d_pend = 0;
      if (!i_pend && $urandom_range(2, 0) == 0) begin
         i_pend = 1;
         bus.i_addr = $urandom;
      end
      if (!d_pend && $urandom_range(2, 0) == 0) begin
         d_pend = 1;
         op = int'($urandom_range(3, 0));
         bus.d_addr      = $urandom;
         bus.d_wdata     = $urandom;
         bus.d_byte_size = 2'($urandom_range(3, 0));
         bus.d_read      = (op != 2);
         bus.d_write     = (op >= 2);
      end
      bus.i_read = i_pend;
      if (!d_pend) begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
   endtask

   task automatic tick();
      @(posedge ramclk);
      model_step();
      #1;
      compare_all();
      controller_step();
      if (rand_mode) requester_step();
   endtask

   task automatic drop_requests();
      bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
      i_pend = 0; d_pend = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rand_mode = 0;
      drop_requests();
      bus.i_addr = '0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_byte_size = '0;
      ctrl_reset();
      tick();
      tick();
      rst = 1'b0;
   endtask

   function automatic bit cond(input int what);
      case (what)
         0:       return bus.mem_io_read || bus.mem_io_write;
         1:       return bus.i_ready;
         default: return bus.d_ready;
      endcase
   endfunction

   // Ticks until the condition holds, bounded by limit
   task automatic wait_for(input string tag, input int what, input int limit, output int n);
      n = 0;
      while (!cond(what) && n < limit) begin
         tick();
         n++;
      end
      check_eq(tag, 32'(cond(what)), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish, got running, expected done");
      $fatal(1, "global timeout");
   end

   initial begin
      int n, g, ni, nd;
      bit prev;
      logic [31:0] got_order [4];
      logic [31:0] exp_order [4];

      rst = 1'b1;
      do_reset();
      check_eq("reset_busy",     32'(bus.busy),        32'd0);
      check_eq("reset_mem_addr", bus.mem_io_addr,      32'd0);
      check_eq("reset_mem_read", 32'(bus.mem_io_read), 32'd0);

      // Single fetch with a fixed read value
      c_use_fixed = 1; c_fixed = 32'hDEADBEEF; c_lat_fixed = 4;
      bus.i_addr = 32'h100; bus.i_read = 1'b1;
      wait_for("fetch_issue", 0, 10, n);
      check_eq("fetch_mem_read", 32'(bus.mem_io_read),  32'd1);
      check_eq("fetch_size",     32'(bus.io_byte_size), 32'd0);
      check_eq("fetch_addr",     bus.mem_io_addr,       32'h100);
      wait_for("fetch_ready", 1, 20, n);
      check_eq("fetch_rdata",   bus.i_rdata,         32'hDEADBEEF);
      check_eq("fetch_d_ready", 32'(bus.d_ready),    32'd0);
      drop_requests();
      tick();
      check_eq("fetch_pulse_end", 32'(bus.i_ready), 32'd0);
      repeat (3) tick();

      // Byte store
      c_lat_fixed = 2;
      bus.d_addr = 32'h203; bus.d_wdata = 32'h000000AA; bus.d_byte_size = 2'd1; bus.d_write = 1'b1;
      wait_for("store_issue", 0, 10, n);
      check_eq("store_write", 32'(bus.mem_io_write), 32'd1);
      check_eq("store_addr",  bus.mem_io_addr,       32'h203);
      check_eq("store_size",  32'(bus.io_byte_size), 32'd1);
      check_eq("store_wdata", bus.mem_io_wdata,      32'h000000AA);
      wait_for("store_ready", 2, 20, n);
      drop_requests();
      repeat (3) tick();

      // Contention: both held high, grants must alternate starting with data
      do_reset();
      c_lat_max = 3;
      bus.i_addr = 32'h1000; bus.i_read = 1'b1;
      bus.d_addr = 32'h2000; bus.d_read = 1'b1;
      exp_order[0] = 32'h2000; exp_order[1] = 32'h1000;
      exp_order[2] = 32'h2000; exp_order[3] = 32'h1000;
      for (int k = 0; k < 4; k++) got_order[k] = '0;
      g = 0; ni = 0; nd = 0; n = 0; prev = 0;
      while ((g < 4 || ni + nd < 4) && n < 200) begin
         tick();
         n++;
         if (cond(0) && !prev) begin
            if (g < 4) got_order[g] = bus.mem_io_addr;
            g++;
         end
         prev = cond(0);
         if (bus.i_ready) ni++;
         if (bus.d_ready) nd++;
      end
      for (int k = 0; k < 4; k++) check_eq($sformatf("grant_order_%0d", k), got_order[k], exp_order[k]);
      check_eq("contention_fetch_readies", 32'(ni), 32'd2);
      check_eq("contention_data_readies",  32'(nd), 32'd2);
      drop_requests();
      repeat (4) tick();

      // Stale ready held for 3 cycles after completion delays the next issue
      do_reset();
      c_lat_fixed = 1; c_hold_lo = 4; c_hold_hi = 4;
      bus.i_addr = 32'h3000; bus.i_read = 1'b1;
      bus.d_addr = 32'h4000; bus.d_read = 1'b1;
      wait_for("stale_data_ready", 2, 20, n);
      bus.d_read = 1'b0;
      wait_for("stale_next_issue", 0, 20, n);
      check_eq("stale_gap",  32'(n),          32'd4);
      check_eq("stale_addr", bus.mem_io_addr, 32'h3000);
      wait_for("stale_fetch_ready", 1, 30, n);
      drop_requests();
      repeat (6) tick();

      // Watchdog abort of a data read, then a normal fetch
      do_reset();
      c_drop = 1; c_use_fixed = 1; c_fixed = 32'h12345678; c_lat_fixed = 2;
      bus.i_addr = 32'h5000; bus.i_read = 1'b1;
      bus.d_addr = 32'h6000; bus.d_read = 1'b1;
      wait_for("to_issue", 0, 10, n);
      check_eq("to_first_owner", bus.mem_io_addr, 32'h6000);
      wait_for("to_ready", 2, 40, n);
      check_eq("to_busy_cycles", 32'(n),               32'(TO));
      check_eq("to_rdata",       bus.d_rdata,          32'h0);
      check_eq("to_err",         32'(bus.timeout_err), 32'd1);
      bus.d_read = 1'b0;
      tick();
      check_eq("to_err_pulse", 32'(bus.timeout_err), 32'd0);
      wait_for("to_fetch_ready", 1, 30, n);
      check_eq("to_fetch_rdata", bus.i_rdata,          32'h12345678);
      check_eq("to_fetch_err",   32'(bus.timeout_err), 32'd0);
      drop_requests();
      repeat (3) tick();

      // Reset in the middle of a transaction
      do_reset();
      c_drop = 1;
      bus.d_addr = 32'h7000; bus.d_read = 1'b1;
      wait_for("rst_issue", 0, 10, n);
      repeat (2) tick();
      bus.i_addr = 32'h8000; bus.i_read = 1'b1;
      rst = 1'b1;
      tick();
      check_eq("rst_busy",     32'(bus.busy),        32'd0);
      check_eq("rst_mem_read", 32'(bus.mem_io_read), 32'd0);
      check_eq("rst_d_ready",  32'(bus.d_ready),     32'd0);
      rst = 1'b0;
      wait_for("rst_reissue", 0, 10, n);
      check_eq("rst_first_tie", bus.mem_io_addr, 32'h7000);
      wait_for("rst_ready", 2, 30, n);
      drop_requests();
      repeat (4) tick();

      // Randomized traffic with occasional dropped transactions
      do_reset();
      c_lat_max = 5; c_hold_lo = 1; c_hold_hi = 3;
      rand_mode = 1;
      for (int k = 0; k < 3000; k++) begin
         if (k % 97 == 50 && c_drop == 0) c_drop = 1;
         tick();
      end
      rand_mode = 0;
      drop_requests();
      repeat (20) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
